multicycle_controller: RTL and testbench

- Moore FSM control unit for the 16-bit multi-cycle accumulator CPU.
- Consumes opcode/func from the instruction register and the ALU zero flag; drives every select and enable of the datapath.
- One instruction takes 3–4 cycles; the datapath holds IR, D, R0, Ri and ALUout between states.

---
 rtl/multicycle_controller.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore FSM control unit for the 16-bit multi-cycle accumulator
//             CPU. Decodes opcode/func and drives every datapath select and
//             enable. Optional macro ILLEGAL_TRAP_EN routes undefined opcodes
//             to a sticky TRAP state that raises illegal_op.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int OPC_W   = 4,
  parameter int FUNC_W  = 9,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  output logic               PC_Write,
  output logic               Branch,
  output logic               Jump,
  output logic               IorD,
  output logic               Mem_Read,
  output logic               Mem_Write,
  output logic               IR_Write,
  output logic               Reg_Write,
  output logic               MemtoReg,
  output logic [1:0]         regDst,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [ALUOP_W-1:0] ALUOperation,
  output logic               inst_done,
  output logic               illegal_op
);

  localparam logic [ALUOP_W-1:0] c_ALU_ADD   = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB   = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] c_ALU_AND   = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] c_ALU_OR    = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] c_ALU_NOTA  = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0] c_ALU_PASSB = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] c_ALU_PASSA = ALUOP_W'(4'b0110);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_LD_MEM = 4'd3,
    S_LD_WB  = 4'd4,
    S_ST_MEM = 4'd5,
    S_JMP    = 4'd6,
    S_BRZ    = 4'd7,
    S_C_EX   = 4'd8,
    S_C_WB   = 4'd9,
    S_I_EX   = 4'd10,
    S_I_WB   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_func_onehot;
  logic                  w_c_valid;
  logic [ALUOP_W-1:0]    w_c_aluop;
  logic [ALUOP_W-1:0]    w_i_aluop;
  logic                  w_unused;

  // The zero flag is qualified in the datapath (Branch AND zero), not here.
  assign w_unused = zero;

  // C-type: exactly one func bit set, and that bit is not the NOP bit.
  assign w_func_onehot = (func != '0) && ((func & (func - 1'b1)) == '0);
  assign w_c_valid     = w_func_onehot && !func[7];
  // I-type ALU op comes straight from opcode[1:0]: ADD/SUB/AND/OR.
  assign w_i_aluop     = {{(ALUOP_W-2){1'b0}}, opcode[1:0]};

  // Map one-hot func to the ALU operation; shared by C_EX and C_WB so it holds.
  always_comb begin
    w_c_aluop = c_ALU_ADD;
    case (func)
      9'b000000001: w_c_aluop = c_ALU_PASSA;
      9'b000000010: w_c_aluop = c_ALU_PASSB;
      9'b000000100: w_c_aluop = c_ALU_ADD;
      9'b000001000: w_c_aluop = c_ALU_SUB;
      9'b000010000: w_c_aluop = c_ALU_AND;
      9'b000100000: w_c_aluop = c_ALU_OR;
      9'b001000000: w_c_aluop = c_ALU_NOTA;
      default:      w_c_aluop = c_ALU_ADD;
    endcase
  end

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode; everything defaults to 0.
  always_comb begin
    w_next       = r_state;
    PC_Write     = 1'b0;
    Branch       = 1'b0;
    Jump         = 1'b0;
    IorD         = 1'b0;
    Mem_Read     = 1'b0;
    Mem_Write    = 1'b0;
    IR_Write     = 1'b0;
    Reg_Write    = 1'b0;
    MemtoReg     = 1'b0;
    regDst       = 2'b00;
    ALUsrcA      = 1'b0;
    ALUsrcB      = 2'b00;
    ALUOperation = c_ALU_ADD;
    inst_done    = 1'b0;
    illegal_op   = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_IF;
      S_IF: begin
        Mem_Read = 1'b1;
        IR_Write = 1'b1;
        ALUsrcB  = 2'b01;
        PC_Write = 1'b1;
        w_next   = S_ID;
      end
      S_ID: begin
        case (opcode)
          4'b0000: w_next = S_LD_MEM;
          4'b0001: w_next = S_ST_MEM;
          4'b0010: w_next = S_JMP;
          4'b0100: w_next = S_BRZ;
          4'b1000: w_next = S_C_EX;
          4'b1100, 4'b1101, 4'b1110, 4'b1111: w_next = S_I_EX;
`ifdef ILLEGAL_TRAP_EN
          default: w_next = S_TRAP;
`else
          default: w_next = S_IF;
`endif
        endcase
      end
      S_LD_MEM: begin
        IorD     = 1'b1;
        Mem_Read = 1'b1;
        w_next   = S_LD_WB;
      end
      S_LD_WB: begin
        Reg_Write = 1'b1;
        MemtoReg  = 1'b1;
        inst_done = 1'b1;
        w_next    = S_IF;
      end
      S_ST_MEM: begin
        IorD      = 1'b1;
        Mem_Write = 1'b1;
        inst_done = 1'b1;
        w_next    = S_IF;
      end
      S_JMP: begin
        Jump      = 1'b1;
        PC_Write  = 1'b1;
        inst_done = 1'b1;
        w_next    = S_IF;
      end
      S_BRZ: begin
        ALUsrcA      = 1'b1;
        ALUOperation = c_ALU_SUB;
        Branch       = 1'b1;
        inst_done    = 1'b1;
        w_next       = S_IF;
      end
      S_C_EX: begin
        if (w_c_valid) begin
          ALUsrcA      = 1'b1;
          ALUOperation = w_c_aluop;
          w_next       = S_C_WB;
        end else begin
          inst_done = 1'b1;
          w_next    = S_IF;
        end
      end
      S_C_WB: begin
        Reg_Write    = 1'b1;
        ALUOperation = w_c_aluop;
        regDst       = func[0] ? 2'b01 : 2'b00;
        inst_done    = 1'b1;
        w_next       = S_IF;
      end
      S_I_EX: begin
        ALUsrcA      = 1'b1;
        ALUsrcB      = 2'b10;
        ALUOperation = w_i_aluop;
        w_next       = S_I_WB;
      end
      S_I_WB: begin
        Reg_Write    = 1'b1;
        ALUOperation = w_i_aluop;
        inst_done    = 1'b1;
        w_next       = S_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
        w_next     = S_TRAP;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Self-checking bench for multicycle_controller. A per-instruction
//             reference model lists the expected control word for every
//             cycle from IF to the last state; directed cases plus random
//             instructions are compared cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       br;
    logic       jmp;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       m2r;
    logic [1:0] rdst;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] op;
    logic       done;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [8:0] func;
  logic       zero;
  logic       PC_Write, Branch, Jump, IorD, Mem_Read, Mem_Write, IR_Write;
  logic       Reg_Write, MemtoReg, ALUsrcA, inst_done, illegal_op;
  logic [1:0] regDst, ALUsrcB;
  logic [3:0] ALUOperation;

  ctl_t obs;
  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .PC_Write(PC_Write), .Branch(Branch), .Jump(Jump), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Reg_Write(Reg_Write), .MemtoReg(MemtoReg), .regDst(regDst),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUOperation(ALUOperation),
    .inst_done(inst_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {PC_Write, Branch, Jump, IorD, Mem_Read, Mem_Write, IR_Write,
                Reg_Write, MemtoReg, regDst, ALUsrcA, ALUsrcB, ALUOperation,
                inst_done, illegal_op};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, want);
    end
  endtask

  function automatic bit is_defined(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b1100, 4'b1101, 4'b1110, 4'b1111};
  endfunction

  // Expected control-word sequence for one instruction, IF through last state.
  function automatic void build_expected(input logic [3:0] op, input logic [8:0] f);
    ctl_t e;
    int   hot;
    int   bitpos;
    logic [3:0] c_ops [0:6];
    c_ops = '{4'b0110, 4'b0101, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
    exp_q.delete();
    e = '0; e.mr = 1; e.irw = 1; e.asb = 2'b01; e.pcw = 1;
    exp_q.push_back(e);                       // IF
    e = '0;
    exp_q.push_back(e);                       // ID
    if (op == 4'b0000) begin
      e = '0; e.iord = 1; e.mr = 1; exp_q.push_back(e);
      e = '0; e.rw = 1; e.m2r = 1; e.done = 1; exp_q.push_back(e);
    end else if (op == 4'b0001) begin
      e = '0; e.iord = 1; e.mw = 1; e.done = 1; exp_q.push_back(e);
    end else if (op == 4'b0010) begin
      e = '0; e.jmp = 1; e.pcw = 1; e.done = 1; exp_q.push_back(e);
    end else if (op == 4'b0100) begin
      e = '0; e.asa = 1; e.op = 4'b0001; e.br = 1; e.done = 1; exp_q.push_back(e);
    end else if (op == 4'b1000) begin
      hot = $countones(f);
      bitpos = 0;
      for (int i = 0; i < 9; i++) if (f[i]) bitpos = i;
      if (hot == 1 && bitpos <= 6) begin
        e = '0; e.asa = 1; e.op = c_ops[bitpos]; exp_q.push_back(e);
        e = '0; e.rw = 1; e.op = c_ops[bitpos]; e.done = 1;
        e.rdst = (bitpos == 0) ? 2'b01 : 2'b00;
        exp_q.push_back(e);
      end else begin
        e = '0; e.done = 1; exp_q.push_back(e);
      end
    end else if (op[3:2] == 2'b11) begin
      e = '0; e.asa = 1; e.asb = 2'b10; e.op = {2'b00, op[1:0]}; exp_q.push_back(e);
      e = '0; e.rw = 1; e.op = {2'b00, op[1:0]}; e.done = 1; exp_q.push_back(e);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        e = '0; e.ill = 1; exp_q.push_back(e);
      end
`endif
    end
  endfunction

  // Starts at the negedge of an IF cycle, ends at the negedge after the last state.
  task automatic run_instr(input logic [3:0] op, input logic [8:0] f, input logic z);
    opcode = op; func = f; zero = z;
    build_expected(op, f);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("op%h_f%h_c%0d", op, f, i), obs, exp_q[i]);
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Hold reset for 3 cycles, release, check IDLE, and step into IF.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1 check({tag, "_rst"}, obs, 20'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check({tag, "_idle"}, obs, 20'h0);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    logic [8:0] f;
    int         r;
    ctl_t       e;
    reset = 1'b1; opcode = '0; func = '0; zero = 1'b0;
    @(negedge clk);
    apply_reset("init");

    // Directed cases from the test plan.
    run_instr(4'b0000, 9'h000, 1'b0);               // LOAD
    run_instr(4'b1000, 9'b000000100, 1'b0);         // C ADD
    run_instr(4'b1000, 9'b000000001, 1'b0);         // C MOVETO
    run_instr(4'b0100, 9'h000, 1'b1);               // BRZ taken
    run_instr(4'b0100, 9'h000, 1'b0);               // BRZ not taken
    run_instr(4'b1000, 9'b010000000, 1'b0);         // C NOP
    run_instr(4'b1000, 9'b000000000, 1'b0);         // C zero func
    run_instr(4'b1000, 9'b000011000, 1'b0);         // C multi-hot
    run_instr(4'b0001, 9'h000, 1'b0);               // STORE
    run_instr(4'b0010, 9'h000, 1'b0);               // JUMP

    // SUBI interrupted by reset during I_EX.
    opcode = 4'b1101; func = '0; zero = 1'b0;
    build_expected(4'b1101, 9'h000);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("subi_pre_c%0d", i), obs, exp_q[i]);
      if (i < 2) begin @(posedge clk); @(negedge clk); end
    end
    apply_reset("subi_abort");
    run_instr(4'b1101, 9'h000, 1'b0);               // SUBI complete

    // Undefined opcode.
    run_instr(4'b0011, 9'h000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    apply_reset("trap");
`endif
    e = '0; e.mr = 1; e.irw = 1; e.asb = 2'b01; e.pcw = 1;
    check("after_undef_if", obs, e);

    // Random instruction stream.
    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom_range(0, 15));
`ifdef ILLEGAL_TRAP_EN
      if (!is_defined(op)) op = 4'b0000;
`endif
      r = $urandom_range(0, 9);
      if (r <= 7)      f = 9'(1 << r);
      else if (r == 8) f = 9'h000;
      else begin
        f = 9'(1 << $urandom_range(0, 8));
        f = f | 9'(1 << $urandom_range(0, 8));
        if ($countones(f) < 2) f = f | 9'b100000000 | 9'b000000001;
      end
      run_instr(op, f, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
